servo_pwm_array: RTL and testbench
==================================

// Module: servo_pwm_array
// PURPOSE
//   Parametrised N-channel hobby-servo PWM generator with an Avalon-MM slave register file.
//   Replaces the single-channel servo_control PIO exports in Computer_System.
//   Period, pulse limits and channel count are set by parameters.
//   Pulse widths are double-buffered and change only at frame boundaries, so no pulse is ever glitched.
// PARAMETERS
//   NUM_CH      8        number of servo outputs, 1..31
//   ADDR_W      4        word-address width; requires NUM_CH+3 <= 2**ADDR_W
//   PW_W        20       width of the period counter and pulse-width fields
//   PERIOD_CYC  1000000  frame length in clk cycles (20 ms at 50 MHz)
//   MIN_PW      50000    minimum pulse width in cycles (1 ms)
//   MAX_PW      100000   maximum pulse width in cycles (2 ms)
// PORTS
//   clk        in   1          system clock
//   reset      in   1          synchronous, active-high
//   address    in   ADDR_W     Avalon word address
//   write      in   1          write strobe
//   writedata  in   32         write data
//   read       in   1          read strobe
//   readdata   out  32         read data, 1-cycle latency
//   servo_pwm  out  NUM_CH     PWM outputs, registered
// BEHAVIOUR
//   Address map (register field widths and read behaviour):
//     0        CTRL: bit0 = global enable; bits[NUM_CH:1] = per-channel enable. R/W.
//     1        STATUS: frame_count[15:0]. RO; writes are ignored.
//     2..NUM_CH+1  TARGET[i] (PW_W bits). R/W.
//     NUM_CH+2 STEP (PW_W bits, ramp feature only).
//     All other addresses read 0; writes to them are ignored.
//   Reset:
//     - servo_pwm=0, readdata=0, CTRL=0, frame_count=0, cnt=0, STEP=0.
//     - TARGET[i] = ACTIVE[i] = (MIN_PW+MAX_PW)/2.
//   Writes to TARGET: value is clamped to [MIN_PW, MAX_PW] on write. Readback returns the clamped value.
//   Reads: readdata is valid the cycle after read=1, held until the next read; no waitrequest.
//   Frame counter cnt:
//     - Runs 0..PERIOD_CYC-1 and wraps while CTRL[0]=1.
//     - While CTRL[0]=0, cnt is held at 0 and all servo_pwm=0.
//     - After CTRL[0] goes 0->1, the first frame starts the following cycle with cnt=0.
//   Frame boundary (cnt==PERIOD_CYC-1, enabled):
//     - ACTIVE[i] loads from TARGET[i]; frame_count increments and wraps 0xFFFF->0.
//     - If a TARGET write lands on the same cycle, the pre-write TARGET is loaded; the new value applies one frame later.
//   Output: servo_pwm[i] <= CTRL[0] & CTRL[i+1] & (cnt < ACTIVE[i]).
//     - This gives exactly ACTIVE[i] high cycles at the start of each frame, delayed 1 cycle from cnt.
//   A channel disabled mid-frame drops low on the next cycle. Re-enabling it resumes at the current cnt position.
//   Reset asserted mid-frame: all state returns to reset values on the next edge and outputs drop low.
// CONFIGURATION
//   SERVO_PWM_RAMP_EN defined:
//     - STEP register exists.
//     - At each frame boundary, ACTIVE[i] moves toward TARGET[i] by min(|TARGET-ACTIVE|, STEP).
//     - STEP=0 means no limit (ACTIVE loads TARGET directly).
//   SERVO_PWM_RAMP_EN undefined:
//     - Address NUM_CH+2 reads 0 and ignores writes.
//     - ACTIVE[i] loads TARGET[i] directly at each boundary.
// TESTING (bench overrides PERIOD_CYC=1000, MIN_PW=50, MAX_PW=100, NUM_CH=4)
//   Reset test: after reset, read TARGET0 -> 75. servo_pwm=0 for 2000 cycles while CTRL=0.
//   Basic PWM: write CTRL=0x1F -> every channel gives 75-cycle pulses repeating every 1000 cycles.
//     STATUS increments by 1 per frame.
//   Clamp test:
//     - Write TARGET1=10 -> readback 50.
//     - Write TARGET1=500 -> readback 100 and ch1 gives 100-cycle pulses.
//   Double-buffer test: write TARGET0=60 at cnt=40 -> current frame pulse is still 75; next frame pulse is 60.
//     Write on cnt==999 -> effect delayed one extra frame.
//   Channel mask: CTRL=0x05 -> only ch1 pulses; ch0, ch2, ch3 stay low.
//     Clear ch1 mid-pulse -> low the next cycle.
//   Ramp test (SERVO_PWM_RAMP_EN): STEP=10, TARGET0 75->100 -> successive pulses 85, 95, 100, 100.
//     Without the macro, addr 6 reads 0.

Source files
------------

// File: rtl/servo_pwm_array.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_array
// Description : N-channel servo PWM generator with an Avalon-MM register file.
//               Pulse widths are double-buffered and update on frame boundaries.
//               Define SERVO_PWM_RAMP_EN to enable the STEP slew limiter.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_array #(
    parameter int NUM_CH     = 8,
    parameter int ADDR_W     = 4,
    parameter int PW_W       = 20,
    parameter int PERIOD_CYC = 1000000,
    parameter int MIN_PW     = 50000,
    parameter int MAX_PW     = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic              read,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] servo_pwm
);

    localparam logic [PW_W-1:0] c_min_pw   = PW_W'(MIN_PW);
    localparam logic [PW_W-1:0] c_max_pw   = PW_W'(MAX_PW);
    localparam logic [PW_W-1:0] c_mid_pw   = PW_W'((MIN_PW + MAX_PW) / 2);
    localparam logic [PW_W-1:0] c_last_cnt = PW_W'(PERIOD_CYC - 1);

    logic [NUM_CH:0]                r_ctrl;
    logic [15:0]                    r_frame_count;
    logic [PW_W-1:0]                r_cnt;
    logic [NUM_CH-1:0][PW_W-1:0]    r_target;
    logic [NUM_CH-1:0][PW_W-1:0]    r_active;
    logic [NUM_CH-1:0][PW_W-1:0]    w_next_active;
    logic [PW_W-1:0]                w_wr_pw;
    logic [31:0]                    w_rdata;
    logic                           w_boundary;

    assign w_boundary = r_ctrl[0] && (r_cnt == c_last_cnt);

    // Clamp against the full 32-bit write value so large writes saturate high.
    always_comb begin
        w_wr_pw = writedata[PW_W-1:0];
        if (writedata < 32'(MIN_PW)) begin
            w_wr_pw = c_min_pw;
        end else if (writedata > 32'(MAX_PW)) begin
            w_wr_pw = c_max_pw;
        end
    end

`ifdef SERVO_PWM_RAMP_EN
    localparam logic [ADDR_W-1:0] c_step_addr = ADDR_W'(NUM_CH + 2);

    logic [PW_W-1:0] r_step;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ramp
        logic            w_up;
        logic [PW_W-1:0] w_diff;

        assign w_up   = r_target[gi] > r_active[gi];
        assign w_diff = w_up ? (r_target[gi] - r_active[gi]) : (r_active[gi] - r_target[gi]);
        // STEP of zero means unlimited slew.
        assign w_next_active[gi] = ((r_step == '0) || (w_diff <= r_step)) ? r_target[gi] :
                                   w_up ? (r_active[gi] + r_step) : (r_active[gi] - r_step);
    end
`else
    assign w_next_active = r_target;
`endif

    always_comb begin
        w_rdata = '0;
        if (address == ADDR_W'(0)) begin
            w_rdata = 32'(r_ctrl);
        end else if (address == ADDR_W'(1)) begin
            w_rdata = {16'h0000, r_frame_count};
        end
`ifdef SERVO_PWM_RAMP_EN
        if (address == c_step_addr) begin
            w_rdata = 32'(r_step);
        end
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (address == ADDR_W'(i + 2)) begin
                w_rdata = 32'(r_target[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl        <= '0;
            r_frame_count <= '0;
            r_cnt         <= '0;
            r_target      <= {NUM_CH{c_mid_pw}};
            r_active      <= {NUM_CH{c_mid_pw}};
            readdata      <= '0;
            servo_pwm     <= '0;
`ifdef SERVO_PWM_RAMP_EN
            r_step        <= '0;
`endif
        end else begin
            if (!r_ctrl[0] || (r_cnt == c_last_cnt)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + PW_W'(1);
            end

            // Boundary load sees the pre-write TARGET; a same-cycle write lands next frame.
            if (w_boundary) begin
                r_active      <= w_next_active;
                r_frame_count <= r_frame_count + 16'd1;
            end

            if (write) begin
                if (address == ADDR_W'(0)) begin
                    r_ctrl <= writedata[NUM_CH:0];
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if (address == ADDR_W'(i + 2)) begin
                        r_target[i] <= w_wr_pw;
                    end
                end
`ifdef SERVO_PWM_RAMP_EN
                if (address == c_step_addr) begin
                    r_step <= writedata[PW_W-1:0];
                end
`endif
            end

            if (read) begin
                readdata <= w_rdata;
            end

            for (int i = 0; i < NUM_CH; i++) begin
                servo_pwm[i] <= r_ctrl[0] & r_ctrl[i+1] & (r_cnt < r_active[i]);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_pwm_array
// Description : Randomized self-checking bench for servo_pwm_array against a
//               frame-level reference model (honours SERVO_PWM_RAMP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_array;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 4;
    localparam int PW_W   = 20;
    localparam int P      = 1000;
    localparam int MIN_PW = 50;
    localparam int MAX_PW = 100;
    localparam int MID_PW = (MIN_PW + MAX_PW) / 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] address = '0;
    logic              write = 1'b0;
    logic [31:0]       writedata = '0;
    logic              read = 1'b0;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] servo_pwm;

    servo_pwm_array #(
        .NUM_CH    (NUM_CH),
        .ADDR_W    (ADDR_W),
        .PW_W      (PW_W),
        .PERIOD_CYC(P),
        .MIN_PW    (MIN_PW),
        .MAX_PW    (MAX_PW)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .write    (write),
        .writedata(writedata),
        .read     (read),
        .readdata (readdata),
        .servo_pwm(servo_pwm)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: register file plus a time-based frame position.
    logic [NUM_CH:0] m_ctrl;
    int              m_target [NUM_CH];
    int              m_active [NUM_CH];
    int              m_step;
    int              m_fc;
    logic [31:0]     m_rd;
    int              cyc = 0;
    int              t_base = 0;
    int              hi_cnt [NUM_CH];
    int              exp_hi [NUM_CH];
    int              last_hi [NUM_CH];
    int              shape_err [NUM_CH];

    function automatic int clamp_pw(input logic [31:0] v);
        if (v < 32'(MIN_PW)) return MIN_PW;
        if (v > 32'(MAX_PW)) return MAX_PW;
        return int'(v);
    endfunction

    function automatic int ramp_to(input int a, input int t, input int s);
        if (s == 0) return t;
        if (t > a) return (a + s < t) ? a + s : t;
        return (a - s > t) ? a - s : t;
    endfunction

    function automatic logic [31:0] reg_val(input int a);
        if (a == 0) return 32'(m_ctrl);
        if (a == 1) return 32'(m_fc);
        if (a >= 2 && a < NUM_CH + 2) return 32'(m_target[a-2]);
`ifdef SERVO_PWM_RAMP_EN
        if (a == NUM_CH + 2) return 32'(m_step);
`endif
        return 32'd0;
    endfunction

    function automatic int cur_cnt();
        return m_ctrl[0] ? (cyc - t_base) % P : 0;
    endfunction

    task automatic clear_acc();
        for (int i = 0; i < NUM_CH; i++) begin
            hi_cnt[i] = 0;
            exp_hi[i] = 0;
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0;
        m_step = 0;
        m_fc   = 0;
        m_rd   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_target[i] = MID_PW;
            m_active[i] = MID_PW;
        end
        clear_acc();
    endtask

    // One clock edge: score outputs against the model, then advance the model.
    task automatic tick();
        int pre;
        int a;
        logic [NUM_CH:0] nc;
        logic eb;
        @(posedge clk);
        #1;
        cyc++;
        pre = m_ctrl[0] ? (cyc - 1 - t_base) % P : 0;
        for (int i = 0; i < NUM_CH; i++) begin
            eb = m_ctrl[0] && m_ctrl[i+1] && (pre < m_active[i]);
            if (servo_pwm[i]) hi_cnt[i]++;
            if (eb) exp_hi[i]++;
            if (servo_pwm[i] !== eb) shape_err[i]++;
        end
        a = int'(address);
        if (read) m_rd = reg_val(a);
        if (m_ctrl[0] && pre == P - 1) begin
            m_fc = (m_fc + 1) & 16'hFFFF;
            for (int i = 0; i < NUM_CH; i++) begin
                check_eq($sformatf("width_ch%0d", i), hi_cnt[i], exp_hi[i]);
                last_hi[i] = hi_cnt[i];
                m_active[i] = ramp_to(m_active[i], m_target[i], m_step);
            end
            clear_acc();
        end
        if (write) begin
            if (a == 0) begin
                nc = writedata[NUM_CH:0];
                if (!m_ctrl[0] && nc[0]) t_base = cyc;
                if (m_ctrl[0] && !nc[0]) clear_acc();
                m_ctrl = nc;
            end else if (a >= 2 && a < NUM_CH + 2) begin
                m_target[a-2] = clamp_pw(writedata);
            end
`ifdef SERVO_PWM_RAMP_EN
            else if (a == NUM_CH + 2) begin
                m_step = int'(writedata[PW_W-1:0]);
            end
`endif
        end
    endtask

    task automatic do_write(input int a, input logic [31:0] d);
        address   = ADDR_W'(a);
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
    endtask

    task automatic do_read(input int a, input string tag, output logic [31:0] v);
        address = ADDR_W'(a);
        read    = 1'b1;
        tick();
        read    = 1'b0;
        check_eq(tag, readdata, m_rd);
        v = readdata;
    endtask

    // Advance until the next edge will see frame position p.
    task automatic wait_pos(input int p);
        int n = 0;
        while (cur_cnt() != p && n < 2 * P + 2) begin
            tick();
            n++;
        end
        if (cur_cnt() != p) check_eq("wait_pos_timeout", 32'(cur_cnt()), 32'(p));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        write = 1'b0;
        read  = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_pwm", 32'(servo_pwm), 32'd0);
        check_eq("rst_rdata", readdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    logic [31:0] v;
    logic [31:0] s1;
    logic [31:0] s2;

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            shape_err[i] = 0;
            last_hi[i]   = 0;
        end
        model_reset();
        do_reset();

        // Reset state and idle outputs
        do_read(2, "rst_target0", v);
        check_eq("rst_target0_lit", v, 32'(MID_PW));
        repeat (2000) tick();
        for (int i = 0; i < NUM_CH; i++) check_eq($sformatf("idle_ch%0d", i), hi_cnt[i], 0);
        clear_acc();

        // Basic PWM and frame counter
        do_write(0, 32'h1F);
        wait_pos(0);
        tick();
        wait_pos(0);
        for (int i = 0; i < NUM_CH; i++) check_eq($sformatf("basic_ch%0d", i), last_hi[i], 32'(MID_PW));
        do_read(1, "status_a", s1);
        repeat (P - 1) tick();
        do_read(1, "status_b", s2);
        check_eq("status_inc", s2 - s1, 32'd1);

        // Clamp
        do_write(3, 32'd10);
        do_read(3, "clamp_lo", v);
        check_eq("clamp_lo_lit", v, 32'(MIN_PW));
        do_write(3, 32'd500);
        do_read(3, "clamp_hi", v);
        check_eq("clamp_hi_lit", v, 32'(MAX_PW));
        repeat (2) begin
            tick();
            wait_pos(0);
        end
        check_eq("clamp_hi_pulse", last_hi[1], 32'(MAX_PW));

        // Double buffering, including a write on the boundary cycle
        wait_pos(40);
        do_write(2, 32'd60);
        wait_pos(0);
        check_eq("dbuf_cur", last_hi[0], 32'(MID_PW));
        wait_pos(999);
        do_write(2, 32'd80);
        check_eq("dbuf_next", last_hi[0], 32'd60);
        tick();
        wait_pos(0);
        check_eq("dbuf_late", last_hi[0], 32'd60);
        tick();
        wait_pos(0);
        check_eq("dbuf_apply", last_hi[0], 32'd80);

        // Channel mask and mid-pulse disable
        do_write(0, 32'h05);
        tick();
        wait_pos(30);
        do_write(0, 32'h01);
        check_eq("mask_pre", 32'(servo_pwm), 32'b0010);
        tick();
        check_eq("mask_drop", 32'(servo_pwm), 32'd0);
        do_write(0, 32'h1F);

`ifdef SERVO_PWM_RAMP_EN
        do_write(2, 32'd75);
        tick();
        wait_pos(0);
        do_write(6, 32'd10);
        wait_pos(500);
        do_write(2, 32'd100);
        wait_pos(0);
        for (int k = 0; k < 4; k++) begin
            tick();
            wait_pos(0);
            check_eq($sformatf("ramp_%0d", k), last_hi[0], (k == 0) ? 32'd85 : (k == 1) ? 32'd95 : 32'd100);
        end
`else
        do_write(6, 32'd123);
        do_read(6, "addr6", v);
        check_eq("addr6_lit", v, 32'd0);
`endif

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0, 1: begin
                    wait_pos($urandom_range(0, P - 1));
                    do_write($urandom_range(2, NUM_CH + 1), 32'($urandom_range(0, 160)));
                end
                2: begin
                    do_write(0, {27'd0, 4'($urandom), ($urandom_range(0, 7) != 0)});
                    if (!m_ctrl[0]) begin
                        repeat ($urandom_range(1, 50)) tick();
                        do_write(0, 32'h1F);
                    end
                end
                3: do_read($urandom_range(0, 15), "rand_read", v);
                4: begin
                    do_write($urandom_range(NUM_CH + 2, 15), 32'($urandom_range(0, 30)));
                    do_read($urandom_range(0, 15), "rand_read2", v);
                end
                default: begin
                    repeat ($urandom_range(1, 1500)) tick();
                    check_eq("rd_hold", readdata, m_rd);
                end
            endcase
        end

        // Reset mid-frame
        do_write(0, 32'h1F);
        wait_pos(20);
        do_reset();
        do_read(2, "post_rst_target0", v);
        check_eq("post_rst_lit", v, 32'(MID_PW));
        do_read(0, "post_rst_ctrl", v);

        for (int i = 0; i < NUM_CH; i++) check_eq($sformatf("shape_ch%0d", i), shape_err[i], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
